// File: rtl/intersection_pkg.sv
// Shared types for the intersection scheduler: phase states, light codes, directions.
// The FLASH state exists only when INTERSECTION_NIGHT_FLASH_EN is defined.
package intersection_pkg;

  typedef enum logic [2:0] {
    ST_NS_GREEN  = 3'd0,
    ST_NS_YELLOW = 3'd1,
    ST_EW_GREEN  = 3'd2,
    ST_EW_YELLOW = 3'd3,
    ST_ALLRED    = 3'd4,
    ST_WALK      = 3'd5
`ifdef INTERSECTION_NIGHT_FLASH_EN
    ,ST_FLASH    = 3'd6
`endif
  } state_e;

  typedef enum logic {
    DIR_NS = 1'b0,
    DIR_EW = 1'b1
  } dir_e;

  // Head encoding {red,yellow,green}, shared with the per-head drivers
  localparam logic [2:0] LIGHT_RED    = 3'b100;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_GREEN  = 3'b001;
  localparam logic [2:0] LIGHT_OFF    = 3'b000;

  function automatic state_e green_of(input dir_e d);
    return (d == DIR_EW) ? ST_EW_GREEN : ST_NS_GREEN;
  endfunction

endpackage

// File: rtl/intersection_scheduler_phase_timer.sv
// Saturating phase counter with synchronous clear; done flags the last cycle
// of a phase lasting dur cycles (cnt == dur-1).
module phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic [CNT_W-1:0] dur,
  output logic [CNT_W-1:0] cnt,
  output logic             done
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_r;

  // Phase counter: clear on request, otherwise count up and hold at all-ones
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (clr) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (cnt_r != CNT_MAX) begin
      cnt_r <= cnt_r + CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt  = cnt_r;
  assign done = (cnt_r == (dur - CNT_ONE));

endmodule

// File: rtl/intersection_scheduler.sv
// Two-approach (NS/EW) intersection controller with latched pedestrian walk phase.
// Optional night flash mode is compiled in with INTERSECTION_NIGHT_FLASH_EN.
module intersection_scheduler
  import intersection_pkg::*;
#(
  parameter int GREEN_MIN   = 4,
  parameter int GREEN_MAX   = 10,
  parameter int YELLOW_TIME = 2,
  parameter int ALLRED_TIME = 1,
  parameter int WALK_TIME   = 3,
  parameter int CNT_W       = 8
`ifdef INTERSECTION_NIGHT_FLASH_EN
  ,parameter int FLASH_PERIOD = 4
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ns_req,
  input  logic       ew_req,
  input  logic       ped_req,
  output logic [2:0] light_ns,
  output logic [2:0] light_ew,
  output logic       walk,
  output logic       ped_ack,
  output logic [2:0] phase
`ifdef INTERSECTION_NIGHT_FLASH_EN
  ,input logic       night_mode
`endif
);

  localparam logic [CNT_W-1:0] GMIN_M1  = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] GMAX_M1  = CNT_W'(GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] D_YELLOW = CNT_W'(YELLOW_TIME);
  localparam logic [CNT_W-1:0] D_ALLRED = CNT_W'(ALLRED_TIME);
  localparam logic [CNT_W-1:0] D_WALK   = CNT_W'(WALK_TIME);
`ifdef INTERSECTION_NIGHT_FLASH_EN
  localparam logic [CNT_W-1:0] D_FLASH  = CNT_W'(FLASH_PERIOD);
`endif

  state_e           state_r, state_s;
  dir_e             next_dir_r, next_dir_s;
  logic             ped_pend_r, ped_pend_s;
  logic [2:0]       light_ns_r, light_ns_s;
  logic [2:0]       light_ew_r, light_ew_s;
  logic             walk_r, walk_s;
  logic             ped_ack_r, ped_ack_s;
  logic [CNT_W-1:0] cnt_s;
  logic [CNT_W-1:0] dur_s;
  logic             done_s;
  logic             clr_s;
  logic             flash_tick_s;
`ifdef INTERSECTION_NIGHT_FLASH_EN
  logic             flash_on_r, flash_on_s;
`endif

  // Gap-out or max-out, but only once min green is served and someone is waiting
  function automatic logic green_exit(input logic [CNT_W-1:0] c,
                                      input logic opp, input logic own);
    return (c >= GMIN_M1) && opp && (!own || (c >= GMAX_M1));
  endfunction

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (clr_s),
    .dur   (dur_s),
    .cnt   (cnt_s),
    .done  (done_s)
  );

  // Duration of the phase currently being timed
  always_comb begin
    dur_s = D_YELLOW;
    case (state_r)
      ST_NS_YELLOW, ST_EW_YELLOW: dur_s = D_YELLOW;
      ST_ALLRED:                  dur_s = D_ALLRED;
      ST_WALK:                    dur_s = D_WALK;
`ifdef INTERSECTION_NIGHT_FLASH_EN
      ST_FLASH:                   dur_s = D_FLASH;
`endif
      default:                    dur_s = D_YELLOW;
    endcase
  end

  // Next-state and direction bookkeeping
  always_comb begin
    state_s    = state_r;
    next_dir_s = next_dir_r;
    case (state_r)
      ST_NS_GREEN: begin
        if (green_exit(cnt_s, ew_req | ped_pend_r, ns_req)) state_s = ST_NS_YELLOW;
        else state_s = state_r;
      end
      ST_EW_GREEN: begin
        if (green_exit(cnt_s, ns_req | ped_pend_r, ew_req)) state_s = ST_EW_YELLOW;
        else state_s = state_r;
      end
      ST_NS_YELLOW: begin
        if (done_s) begin
          state_s    = ST_ALLRED;
          next_dir_s = DIR_EW;
        end else begin
          state_s = state_r;
        end
      end
      ST_EW_YELLOW: begin
        if (done_s) begin
          state_s    = ST_ALLRED;
          next_dir_s = DIR_NS;
        end else begin
          state_s = state_r;
        end
      end
      ST_ALLRED: begin
        if (done_s) begin
`ifdef INTERSECTION_NIGHT_FLASH_EN
          if (night_mode) state_s = ST_FLASH;
          else
`endif
          if (ped_pend_r) state_s = ST_WALK;
          else state_s = green_of(next_dir_r);
        end else begin
          state_s = state_r;
        end
      end
      ST_WALK: begin
        if (done_s) state_s = green_of(next_dir_r);
        else state_s = state_r;
      end
`ifdef INTERSECTION_NIGHT_FLASH_EN
      ST_FLASH: begin
        if (!night_mode) state_s = ST_ALLRED;
        else state_s = state_r;
      end
`endif
      default: state_s = ST_ALLRED;
    endcase
  end

  // Flash blink phase; a blink period restarts the counter without a state change
  always_comb begin
    flash_tick_s = 1'b0;
`ifdef INTERSECTION_NIGHT_FLASH_EN
    flash_on_s = flash_on_r;
    if ((state_s == ST_FLASH) && (state_r != ST_FLASH)) begin
      flash_on_s = 1'b1;
    end else if ((state_r == ST_FLASH) && done_s) begin
      flash_on_s   = !flash_on_r;
      flash_tick_s = 1'b1;
    end else begin
      flash_on_s = flash_on_r;
    end
`endif
    clr_s = (state_s != state_r) | flash_tick_s;
  end

  // Pedestrian latch: cleared on WALK entry, requests during WALK are dropped
  always_comb begin
    ped_pend_s = ped_pend_r;
    if ((state_s == ST_WALK) && (state_r != ST_WALK)) begin
      ped_pend_s = 1'b0;
    end else if (ped_req && (state_r != ST_WALK)) begin
      ped_pend_s = 1'b1;
    end else begin
      ped_pend_s = ped_pend_r;
    end
  end

  // Output decode from the next state so lamps switch with the state register
  always_comb begin
    light_ns_s = LIGHT_RED;
    light_ew_s = LIGHT_RED;
    walk_s     = 1'b0;
    case (state_s)
      ST_NS_GREEN:  light_ns_s = LIGHT_GREEN;
      ST_NS_YELLOW: light_ns_s = LIGHT_YELLOW;
      ST_EW_GREEN:  light_ew_s = LIGHT_GREEN;
      ST_EW_YELLOW: light_ew_s = LIGHT_YELLOW;
      ST_WALK:      walk_s     = 1'b1;
      ST_ALLRED:    walk_s     = 1'b0;
`ifdef INTERSECTION_NIGHT_FLASH_EN
      ST_FLASH: begin
        light_ns_s = flash_on_s ? LIGHT_YELLOW : LIGHT_OFF;
        light_ew_s = flash_on_s ? LIGHT_YELLOW : LIGHT_OFF;
      end
`endif
      default: begin
        light_ns_s = LIGHT_RED;
        light_ew_s = LIGHT_RED;
      end
    endcase
    ped_ack_s = (state_s == ST_WALK) && (state_r != ST_WALK);
  end

  // State, bookkeeping and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ST_ALLRED;
      next_dir_r <= DIR_NS;
      ped_pend_r <= 1'b0;
      light_ns_r <= LIGHT_RED;
      light_ew_r <= LIGHT_RED;
      walk_r     <= 1'b0;
      ped_ack_r  <= 1'b0;
    end else begin
      state_r    <= state_s;
      next_dir_r <= next_dir_s;
      ped_pend_r <= ped_pend_s;
      light_ns_r <= light_ns_s;
      light_ew_r <= light_ew_s;
      walk_r     <= walk_s;
      ped_ack_r  <= ped_ack_s;
    end
  end

`ifdef INTERSECTION_NIGHT_FLASH_EN
  // Blink phase register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) flash_on_r <= 1'b0;
    else flash_on_r <= flash_on_s;
  end
`endif

  assign light_ns = light_ns_r;
  assign light_ew = light_ew_r;
  assign walk     = walk_r;
  assign ped_ack  = ped_ack_r;
  assign phase    = state_r;

endmodule

// File: tb/tb_intersection_scheduler.sv
// Directed bench for intersection_scheduler: expected lamp vectors are queued per
// cycle and popped against the DUT one cycle at a time.
module tb_intersection_scheduler;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;
  localparam logic [2:0] O = 3'b000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ns_req = 1'b0;
  logic       ew_req = 1'b0;
  logic       ped_req = 1'b0;
  logic [2:0] light_ns, light_ew, phase;
  logic       walk, ped_ack;
`ifdef INTERSECTION_NIGHT_FLASH_EN
  logic       night_mode = 1'b0;
`endif

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q[$];

  intersection_scheduler dut (
    .clk        (clk),
    .reset      (reset),
    .ns_req     (ns_req),
    .ew_req     (ew_req),
    .ped_req    (ped_req),
    .light_ns   (light_ns),
    .light_ew   (light_ew),
    .walk       (walk),
    .ped_ack    (ped_ack),
    .phase      (phase)
`ifdef INTERSECTION_NIGHT_FLASH_EN
    ,.night_mode (night_mode)
`endif
  );

  always #5 clk = ~clk;

  task automatic push_exp(input logic [2:0] ns, input logic [2:0] ew,
                          input logic wk, input logic ack, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({ns, ew, wk, ack});
  endtask

  task automatic compare(input string tag);
    logic [7:0] e;
    logic [7:0] o;
    o = {light_ns, light_ew, walk, ped_ack};
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $error("FAIL %s: observed %b but no expected entry queued", tag, o);
    end else begin
      e = exp_q.pop_front();
      assert (o === e) else begin
        fails++;
        $error("FAIL %s: observed ns=%b ew=%b walk=%b ack=%b expected ns=%b ew=%b walk=%b ack=%b",
               tag, o[7:5], o[4:2], o[1], o[0], e[7:5], e[4:2], e[1], e[0]);
      end
    end
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      compare(tag);
    end
  endtask

  // Holds reset over one edge, then releases it; RED/RED persists until the next edge
  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    push_exp(R, R, 1'b0, 1'b0, 1);
    compare("reset_state");
    reset = 1'b0;
    push_exp(R, R, 1'b0, 1'b0, 1);
    compare("post_reset_allred");
  endtask

  initial begin
    @(posedge clk);
    #1;

    // 1: no demand, NS rests in green
    do_reset();
    push_exp(G, R, 1'b0, 1'b0, 50);
    run("idle_ns_green", 50);

    // 2: EW demand only, NS gaps out at min green
    ew_req = 1'b1;
    do_reset();
    push_exp(G, R, 1'b0, 1'b0, 4);
    push_exp(Y, R, 1'b0, 1'b0, 2);
    push_exp(R, R, 1'b0, 1'b0, 1);
    push_exp(R, G, 1'b0, 1'b0, 3);
    run("gap_out", 10);

    // 3: both held, max-out in both directions
    ns_req = 1'b1;
    ew_req = 1'b1;
    do_reset();
    push_exp(G, R, 1'b0, 1'b0, 10);
    push_exp(Y, R, 1'b0, 1'b0, 2);
    push_exp(R, R, 1'b0, 1'b0, 1);
    push_exp(R, G, 1'b0, 1'b0, 10);
    push_exp(R, Y, 1'b0, 1'b0, 2);
    push_exp(R, R, 1'b0, 1'b0, 1);
    push_exp(G, R, 1'b0, 1'b0, 2);
    run("max_out", 28);

    // 4: pedestrian pulse during NS green; repeat press during WALK ignored
    ns_req = 1'b0;
    ew_req = 1'b0;
    do_reset();
    push_exp(G, R, 1'b0, 1'b0, 1);
    run("ped_green", 1);
    ped_req = 1'b1;
    push_exp(G, R, 1'b0, 1'b0, 1);
    run("ped_green", 1);
    ped_req = 1'b0;
    push_exp(G, R, 1'b0, 1'b0, 2);
    run("ped_green", 2);
    push_exp(Y, R, 1'b0, 1'b0, 2);
    push_exp(R, R, 1'b0, 1'b0, 1);
    push_exp(R, R, 1'b1, 1'b1, 1);
    run("ped_clear_walk", 4);
    ped_req = 1'b1;
    push_exp(R, R, 1'b1, 1'b0, 1);
    run("ped_walk", 1);
    ped_req = 1'b0;
    push_exp(R, R, 1'b1, 1'b0, 1);
    push_exp(R, G, 1'b0, 1'b0, 6);
    run("ped_no_rewalk", 7);

    // 5: asynchronous reset between edges during EW yellow
    ns_req = 1'b1;
    ew_req = 1'b1;
    do_reset();
    push_exp(G, R, 1'b0, 1'b0, 10);
    push_exp(Y, R, 1'b0, 1'b0, 2);
    push_exp(R, R, 1'b0, 1'b0, 1);
    push_exp(R, G, 1'b0, 1'b0, 10);
    push_exp(R, Y, 1'b0, 1'b0, 1);
    run("to_ew_yellow", 24);
    #2;
    reset = 1'b1;
    #1;
    push_exp(R, R, 1'b0, 1'b0, 1);
    compare("async_reset");
    ns_req = 1'b0;
    ew_req = 1'b0;
    do_reset();
    push_exp(G, R, 1'b0, 1'b0, 12);
    run("restart_ns_green", 12);

`ifdef INTERSECTION_NIGHT_FLASH_EN
    // 6: night flash from ALLRED, then back through a full all-red
    night_mode = 1'b1;
    do_reset();
    push_exp(Y, Y, 1'b0, 1'b0, 4);
    push_exp(O, O, 1'b0, 1'b0, 4);
    push_exp(Y, Y, 1'b0, 1'b0, 2);
    run("flash", 10);
    night_mode = 1'b0;
    push_exp(R, R, 1'b0, 1'b0, 1);
    push_exp(G, R, 1'b0, 1'b0, 3);
    run("flash_exit", 4);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
